riscv_checkpoint_mon: RTL and testbench



---
 rtl/riscv_chk_pkg.sv | 24 ++
 rtl/riscv_chk_table.sv | 40 ++++
 rtl/riscv_checkpoint_mon.sv | 163 ++++++++++++++++
 tb/tb_riscv_checkpoint_mon.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_chk_pkg.sv
// Shared definitions for the RISC-V checkpoint monitor.
//   chk_state_t : monitor FSM states
//   FC_*        : FAIL_CODE values reported on failure
//   chk_entry_t : one checkpoint table entry {num_inst, ans}
package riscv_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_t;

  localparam logic [1:0] FC_MISMATCH   = 2'd0;
  localparam logic [1:0] FC_SKIP       = 2'd1;
  localparam logic [1:0] FC_INCOMPLETE = 2'd2;
  localparam logic [1:0] FC_TIMEOUT    = 2'd3;

  typedef struct packed {
    logic [31:0] num_inst;
    logic [31:0] ans;
  } chk_entry_t;

endpackage

// File: rtl/riscv_chk_table.sv
// Checkpoint table: NUM_CHK x 64-bit register array.
//   clk_i : clock
//   we_i  : write strobe (already qualified by the caller's state)
//   wa_i  : write index; indices >= NUM_CHK are dropped
//   wd_i  : write data
//   ra_i  : read index (combinational read)
//   rd_o  : read data, '0 for indices >= NUM_CHK
// No reset: contents are undefined until software loads them.
module riscv_chk_table
  import riscv_chk_pkg::*;
#(
  parameter int NUM_CHK = 40,
  parameter int AW      = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  chk_entry_t    wd_i,
  input  logic [AW-1:0] ra_i,
  output chk_entry_t    rd_o
);

  localparam logic [AW:0] DEPTH = (AW+1)'(NUM_CHK);

  chk_entry_t mem_q [NUM_CHK];

  always_ff @(posedge clk_i) begin
    if (we_i && ({1'b0, wa_i} < DEPTH)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd_o = '0;
    if ({1'b0, ra_i} < DEPTH) begin
      rd_o = mem_q[ra_i];
    end
  end

endmodule

// File: rtl/riscv_checkpoint_mon.sv
// RISC-V checkpoint monitor.
// Compares the core's retired-instruction count and OUTPUT_PORT against a
// table of expected checkpoints while in RUN, and reports PASS at HALT or a
// coded FAIL (mismatch, skipped checkpoint, incomplete at HALT, timeout).
// Ports:
//   CLK, RST                  : clock, synchronous active-high reset
//   TBL_WE/TBL_WA             : table write strobe/index (ignored in RUN)
//   TBL_NUM_INST/TBL_ANS      : table write data
//   NUM_VALID, START          : entry count latched when START arms the run
//   NUM_INST/OUTPUT_PORT/HALT : core observation inputs
//   DONE/PASS/FAIL            : registered verdict, held until START or RST
//   FAIL_CODE/FAIL_IDX/FAIL_VAL : failure details
//   CHK_IDX, CYCLE_CNT        : entries passed, cycles spent in RUN
module riscv_checkpoint_mon
  import riscv_chk_pkg::*;
#(
  parameter int NUM_CHK     = 40,
  parameter int AW          = 6,
  parameter int CYCLE_LIMIT = 1000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          TBL_WE,
  input  logic [AW-1:0] TBL_WA,
  input  logic [31:0]   TBL_NUM_INST,
  input  logic [31:0]   TBL_ANS,
  input  logic [AW:0]   NUM_VALID,
  input  logic          START,
  input  logic [31:0]   NUM_INST,
  input  logic [31:0]   OUTPUT_PORT,
  input  logic          HALT,
  output logic          DONE,
  output logic          PASS,
  output logic          FAIL,
  output logic [1:0]    FAIL_CODE,
  output logic [AW-1:0] FAIL_IDX,
  output logic [31:0]   FAIL_VAL,
  output logic [AW:0]   CHK_IDX,
  output logic [31:0]   CYCLE_CNT
);

  localparam logic [AW:0] DEPTH = (AW+1)'(NUM_CHK);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [31:0] LIMIT = 32'(CYCLE_LIMIT);

  chk_state_t  state_q;
  logic [AW:0] num_valid_q;
  logic [AW:0] chk_idx_q, chk_idx_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        done_q, pass_q, fail_q;
  logic [1:0]  fail_code_q;
  logic [AW-1:0] fail_idx_q;
  logic [31:0] fail_val_q;

  chk_entry_t  entry;
  chk_entry_t  wr_entry;
  logic        tbl_we;
  logic        chk_active, ent_hit, ent_match, ent_mismatch, ent_skip;
  logic        halt_pass, timeout;

  assign tbl_we   = TBL_WE && (state_q != ST_RUN);
  assign wr_entry = '{num_inst: TBL_NUM_INST, ans: TBL_ANS};

  riscv_chk_table #(
    .NUM_CHK (NUM_CHK),
    .AW      (AW)
  ) u_table (
    .clk_i (CLK),
    .we_i  (tbl_we),
    .wa_i  (TBL_WA),
    .wd_i  (wr_entry),
    .ra_i  (chk_idx_q[AW-1:0]),
    .rd_o  (entry)
  );

  // Per-cycle checkpoint evaluation against the entry at CHK_IDX.
  always_comb begin
    chk_active   = (state_q == ST_RUN) && (chk_idx_q < num_valid_q) &&
                   (chk_idx_q < DEPTH);
    ent_hit      = chk_active && (NUM_INST == entry.num_inst);
    ent_match    = ent_hit && (OUTPUT_PORT == entry.ans);
    ent_mismatch = ent_hit && !ent_match;
    ent_skip     = chk_active && (NUM_INST > entry.num_inst);
    chk_idx_d    = ent_match ? chk_idx_q + ONE : chk_idx_q;
    cycle_cnt_d  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    // HALT judges completeness on the count including this cycle's match.
    halt_pass    = (chk_idx_d == num_valid_q);
    timeout      = (cycle_cnt_d == LIMIT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      num_valid_q <= '0;
      chk_idx_q   <= '0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= FC_MISMATCH;
      fail_idx_q  <= '0;
      fail_val_q  <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          chk_idx_q   <= chk_idx_d;
          cycle_cnt_q <= cycle_cnt_d;
          if (ent_mismatch || ent_skip) begin
            state_q     <= ST_FAIL;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_code_q <= ent_mismatch ? FC_MISMATCH : FC_SKIP;
            fail_idx_q  <= chk_idx_q[AW-1:0];
            fail_val_q  <= OUTPUT_PORT;
          end else if (HALT) begin
            done_q <= 1'b1;
            if (halt_pass) begin
              state_q <= ST_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q     <= ST_FAIL;
              fail_q      <= 1'b1;
              fail_code_q <= FC_INCOMPLETE;
              fail_idx_q  <= chk_idx_d[AW-1:0];
              fail_val_q  <= OUTPUT_PORT;
            end
          end else if (timeout) begin
            state_q     <= ST_FAIL;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_code_q <= FC_TIMEOUT;
            fail_idx_q  <= chk_idx_d[AW-1:0];
            fail_val_q  <= OUTPUT_PORT;
          end
        end
        default: begin
          if (START) begin
            state_q     <= ST_RUN;
            num_valid_q <= NUM_VALID;
            chk_idx_q   <= '0;
            cycle_cnt_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FC_MISMATCH;
            fail_idx_q  <= '0;
            fail_val_q  <= '0;
          end
        end
      endcase
    end
  end

  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL      = fail_q;
  assign FAIL_CODE = fail_code_q;
  assign FAIL_IDX  = fail_idx_q;
  assign FAIL_VAL  = fail_val_q;
  assign CHK_IDX   = chk_idx_q;
  assign CYCLE_CNT = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_checkpoint_mon.sv
// Testbench for riscv_checkpoint_mon: directed scenarios, a queue-based
// behavioural model compared every cycle, plus literal expectations.
module tb_riscv_checkpoint_mon;

  localparam int NCHK  = 40;
  localparam int AW    = 6;
  localparam int LIMIT = 16;

  logic          clk;
  logic          rst;
  logic          tbl_we;
  logic [AW-1:0] tbl_wa;
  logic [31:0]   tbl_num_inst, tbl_ans;
  logic [AW:0]   num_valid;
  logic          start;
  logic [31:0]   num_inst, output_port;
  logic          halt;
  logic          done_o, pass_o, fail_o;
  logic [1:0]    fail_code;
  logic [AW-1:0] fail_idx;
  logic [31:0]   fail_val;
  logic [AW:0]   chk_idx;
  logic [31:0]   cycle_cnt;

  riscv_checkpoint_mon #(
    .NUM_CHK     (NCHK),
    .AW          (AW),
    .CYCLE_LIMIT (LIMIT)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .TBL_WE       (tbl_we),
    .TBL_WA       (tbl_wa),
    .TBL_NUM_INST (tbl_num_inst),
    .TBL_ANS      (tbl_ans),
    .NUM_VALID    (num_valid),
    .START        (start),
    .NUM_INST     (num_inst),
    .OUTPUT_PORT  (output_port),
    .HALT         (halt),
    .DONE         (done_o),
    .PASS         (pass_o),
    .FAIL         (fail_o),
    .FAIL_CODE    (fail_code),
    .FAIL_IDX     (fail_idx),
    .FAIL_VAL     (fail_val),
    .CHK_IDX      (chk_idx),
    .CYCLE_CNT    (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] n;
    logic [31:0] a;
  } ent_t;

  logic [31:0] mt_n [NCHK];
  logic [31:0] mt_a [NCHK];
  ent_t        pend [$];   // checkpoints still to be met, in order
  bit          m_run = 0, m_decided = 0;
  bit          m_done = 0, m_pass = 0, m_fail = 0;
  int          m_code = 0, m_idx = 0, m_chk = 0;
  logic [31:0] m_val = '0, m_cnt = '0;

  task automatic m_set_fail(input int code);
    m_decided = 1; m_run = 0; m_done = 1; m_fail = 1;
    m_code = code; m_idx = m_chk; m_val = output_port;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; pend.delete();
      m_done = 0; m_pass = 0; m_fail = 0;
      m_code = 0; m_idx = 0; m_val = '0; m_chk = 0; m_cnt = '0;
    end else if (!m_run) begin
      if (tbl_we && int'(tbl_wa) < NCHK) begin
        mt_n[tbl_wa] = tbl_num_inst;
        mt_a[tbl_wa] = tbl_ans;
      end
      if (start) begin
        pend.delete();
        for (int i = 0; i < int'(num_valid); i++) pend.push_back('{mt_n[i], mt_a[i]});
        m_run = 1; m_done = 0; m_pass = 0; m_fail = 0;
        m_code = 0; m_idx = 0; m_val = '0; m_chk = 0; m_cnt = '0;
      end
    end else begin
      m_decided = 0;
      if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
      if (pend.size() > 0) begin
        if (num_inst == pend[0].n) begin
          if (output_port == pend[0].a) begin
            void'(pend.pop_front());
            m_chk++;
          end else m_set_fail(0);
        end else if (num_inst > pend[0].n) m_set_fail(1);
      end
      if (!m_decided && halt) begin
        if (pend.size() == 0) begin
          m_decided = 1; m_run = 0; m_done = 1; m_pass = 1;
        end else m_set_fail(2);
      end
      if (!m_decided && m_cnt == LIMIT) m_set_fail(3);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("DONE", done_o, m_done);
      chk("PASS", pass_o, m_pass);
      chk("FAIL_FLAG", fail_o, m_fail);
      chk("FAIL_CODE", fail_code, m_code);
      chk("FAIL_IDX", fail_idx, m_idx);
      chk("FAIL_VAL", fail_val, m_val);
      chk("CHK_IDX", chk_idx, m_chk);
      chk("CYCLE_CNT", cycle_cnt, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int idx, input logic [31:0] n, input logic [31:0] a);
    tbl_we = 1'b1; tbl_wa = AW'(idx); tbl_num_inst = n; tbl_ans = a;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic arm(input int nv);
    num_valid = (AW+1)'(nv); start = 1'b1;
    num_inst = '0; output_port = '0; halt = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ni, input logic [31:0] op, input logic h);
    num_inst = ni; output_port = op; halt = h;
    @(negedge clk);
    halt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tbl_we = 0; tbl_wa = '0; tbl_num_inst = '0; tbl_ans = '0;
    num_valid = '0; start = 0; num_inst = '0; output_port = '0; halt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_done", done_o, 0);
    chk("rst_cnt", cycle_cnt, 0);

    // Two checkpoints met in order, then HALT.
    load(0, 32'd4, 32'h0f00);
    load(1, 32'd6, 32'h0018);
    arm(2);
    drive(4, 32'h0f00, 0);
    drive(6, 32'h0018, 0);
    drive(6, 32'h0018, 1);
    chk("s1_pass", pass_o, 1);
    chk("s1_chk_idx", chk_idx, 2);
    drive(9, 32'h55, 1);            // ignored once done
    chk("s1_hold", pass_o, 1);

    // Mismatch: verdict appears one cycle after the deciding sample.
    load(0, 32'd8, 32'h001d);
    arm(1);
    chk("s2_pre", fail_o, 0);
    drive(8, 32'h001e, 0);
    chk("s2_fail", fail_o, 1);
    chk("s2_code", fail_code, 0);
    chk("s2_idx", fail_idx, 0);
    chk("s2_val", fail_val, 32'h1e);

    // Skipped checkpoint.
    load(0, 32'h0a, 32'h001e);
    arm(1);
    drive(9, 0, 0);
    chk("s3_noact", fail_o, 0);
    drive(32'h0b, 0, 0);
    chk("s3_code", fail_code, 1);
    chk("s3_fail", fail_o, 1);

    // Incomplete at HALT, then HALT coincident with last match.
    load(0, 32'd1, 32'h11);
    load(1, 32'd2, 32'h22);
    load(2, 32'd3, 32'h33);
    arm(3);
    drive(1, 32'h11, 0);
    drive(2, 32'h22, 0);
    drive(2, 32'h22, 1);
    chk("s4_code", fail_code, 2);
    chk("s4_idx", fail_idx, 2);
    chk("s4_val", fail_val, 32'h22);
    arm(3);
    drive(1, 32'h11, 0);
    drive(2, 32'h22, 0);
    drive(3, 32'h33, 1);
    chk("s4b_pass", pass_o, 1);
    chk("s4b_chk_idx", chk_idx, 3);

    // Entries sharing NUM_INST consumed one per cycle; mismatch beats HALT.
    load(0, 32'd5, 32'h0a);
    load(1, 32'd5, 32'h0b);
    arm(2);
    drive(5, 32'h0a, 0);
    chk("s5_one", chk_idx, 1);
    drive(5, 32'h0b, 0);
    chk("s5_two", chk_idx, 2);
    drive(5, 32'h0b, 1);
    chk("s5_pass", pass_o, 1);
    arm(2);
    drive(5, 32'h0c, 1);
    chk("s5_mm_over_halt", fail_code, 0);
    chk("s5_mm_fail", fail_o, 1);

    // Empty table passes on first HALT.
    arm(0);
    drive(0, 0, 1);
    chk("s6_pass", pass_o, 1);

    // Timeout, and HALT taking priority over it.
    load(0, 32'd100, 32'd1);
    arm(1);
    repeat (15) drive(0, 0, 0);
    chk("s7_pre", fail_o, 0);
    drive(0, 0, 0);
    chk("s7_code", fail_code, 3);
    chk("s7_cnt", cycle_cnt, 16);
    arm(1);
    repeat (15) drive(0, 0, 0);
    drive(0, 0, 1);
    chk("s7_halt_code", fail_code, 2);

    // Reset mid-run, table write during RUN ignored, rerun passes.
    load(0, 32'd4, 32'h0f00);
    load(1, 32'd6, 32'h0018);
    arm(2);
    drive(4, 32'h0f00, 0);
    load(0, 32'd99, 32'd99);
    rst = 1'b1;
    @(negedge clk);
    chk("s8_rst_chk", chk_idx, 0);
    chk("s8_rst_cnt", cycle_cnt, 0);
    chk("s8_rst_done", done_o, 0);
    rst = 1'b0;
    arm(2);
    drive(4, 32'h0f00, 0);
    drive(6, 32'h0018, 0);
    drive(6, 32'h0018, 1);
    chk("s8_pass", pass_o, 1);
    chk("s8_chk_idx", chk_idx, 2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
